// File: rtl/vecaris_print_tx.sv
// Serial print transmitter: buffers each printed 16-bit word in a FIFO and sends it
// on an 8N1 UART line as four uppercase hex digits followed by a line feed.
module vecaris_print_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        print_en,
    input  logic [15:0] print_data,
    input  logic        end_sig,
    output logic        tx,
    output logic        busy,
    output logic        overflow,
    output logic        done
);
    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [15:0]      BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [15:0]      tmr_q, tmr_d;
    logic [2:0]       bit_q, bit_d;
    logic [2:0]       idx_q, idx_d;
    logic [15:0]      word_q, word_d;
    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             end_seen_q, end_seen_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pop, push, full, tmr_last;
    logic [7:0]       char_d;

    function automatic logic [7:0] nib_ascii(input logic [3:0] n);
        logic [7:0] c;
        if (n < 4'd10) c = 8'h30 + {4'h0, n};
        else           c = 8'h37 + {4'h0, n};
        return c;
    endfunction

    function automatic logic [7:0] char_of(input logic [15:0] w, input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0:    c = nib_ascii(w[15:12]);
            3'd1:    c = nib_ascii(w[11:8]);
            3'd2:    c = nib_ascii(w[7:4]);
            3'd3:    c = nib_ascii(w[3:0]);
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    always_comb begin
        full     = (count_q == FULL_CNT);
        pop      = (state_q == IDLE) && (count_q != '0);
        // A full FIFO still accepts a strobe on the edge that pops its head.
        push     = print_en && (!full || pop);
        tmr_last = (tmr_q == BIT_LAST);

        state_d = state_q;
        tmr_d   = tmr_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        word_d  = word_q;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    word_d  = mem_q[rd_ptr_q];
                    idx_d   = 3'd0;
                    tmr_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tmr_last) begin
                    tmr_d   = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            DATA: begin
                if (tmr_last) begin
                    tmr_d = '0;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            STOP: begin
                if (tmr_last) begin
                    tmr_d = '0;
                    if (idx_q == 3'd4) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = START;
                    end
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
        endcase

        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        overflow_d = overflow_q | (print_en & full & ~pop);
        end_seen_d = end_seen_q | end_sig;

        // Outputs are registered from the next state so tx leads the state by no cycle.
        char_d = char_of(word_d, idx_d);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = char_d[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (count_q != '0) || (state_d != IDLE);
        done_d = end_seen_d && !busy_d;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= print_data;
        word_q <= word_d;
        if (!rst) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            bit_q      <= '0;
            idx_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            end_seen_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            bit_q      <= bit_d;
            idx_q      <= idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            end_seen_q <= end_seen_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign done     = done_q;
endmodule

// File: tb/tb_vecaris_print_tx.sv
// Testbench for vecaris_print_tx: a UART receiver decodes tx and is compared against
// an expected character stream built from the pushed words.
module tb_vecaris_print_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int W     = 50 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        print_en = 1'b0;
    logic [15:0] print_data = 16'h0;
    logic        end_sig = 1'b0;
    logic        tx, busy, overflow, done;

    vecaris_print_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .print_en(print_en), .print_data(print_data),
        .end_sig(end_sig), .tx(tx), .busy(busy), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_push;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver: bytes and the cycle their start bit began.
    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic [7:0] exp_q[$];
    int         rx_ferr = 0;
    bit         rx_act = 1'b0;
    int         rx_cnt = 0;
    int         rx_start = 0;
    logic [7:0] rx_sh = 8'h0;

    always @(negedge clk) begin
        if (!rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act   = 1'b1;
                rx_cnt   = 0;
                rx_start = cyc;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == CPB / 2 && tx !== 1'b0) rx_ferr++;
            for (int k = 0; k < 8; k++)
                if (rx_cnt == (k + 1) * CPB + CPB / 2) rx_sh[k] = tx;
            if (rx_cnt == 9 * CPB + CPB / 2) begin
                if (tx !== 1'b1) rx_ferr++;
                rx_q.push_back(rx_sh);
                rx_t.push_back(rx_start);
                rx_act = 1'b0;
            end
        end
    end

    int busy_cnt = 0;
    int done_rise = -1;
    int busy_fall = -1;
    logic done_prev = 1'b0;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1 && done_prev !== 1'b1) done_rise = cyc;
        if (busy !== 1'b1 && busy_prev === 1'b1) busy_fall = cyc;
        done_prev = done;
        busy_prev = busy;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] hex_char(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
    endfunction

    task automatic add_exp(input logic [15:0] w);
        for (int i = 3; i >= 0; i--) exp_q.push_back(hex_char(int'((w >> (4 * i)) & 16'hF)));
        exp_q.push_back(8'h0A);
    endtask

    function automatic int stream_diff();
        int n;
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (rx_q[i] !== exp_q[i]) return i;
        if (rx_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic clear_streams();
        rx_q.delete();
        rx_t.delete();
        exp_q.delete();
        rx_ferr = 0;
    endtask

    task automatic push_word(input logic [15:0] d);
        print_en   = 1'b1;
        print_data = d;
        @(negedge clk);
        print_en  = 1'b0;
        last_push = cyc;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (busy === 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: busy=%b still high, required 0", busy);
        end
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; print_en = 1'b0; end_sig = 1'b0;
        repeat (2) @(negedge clk);
        clear_streams();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (tx !== 1'b1)       begin n_fail++; $display("FAIL reset_tx: got %b required 1", tx); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        clear_streams();
    endtask

    task automatic test_single_word();
        logic [7:0] spec_bytes [5];
        int p;
        spec_bytes = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0A};
        clear_streams();
        busy_cnt = 0;
        push_word(16'h1A2F);
        p = last_push;
        add_exp(16'h1A2F);
        wait_drain();
        n_checks++;
        if (stream_diff() != -1) begin
            n_fail++; $display("FAIL single_stream: %0d bytes, first diff at %0d, required %0d bytes", rx_q.size(), stream_diff(), exp_q.size());
        end
        n_checks++;
        if (rx_q.size() != 5) begin
            n_fail++; $display("FAIL single_count: got %0d bytes required 5", rx_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (rx_q[i] !== spec_bytes[i]) begin
                    n_fail++; $display("FAIL single_byte%0d: got %h required %h", i, rx_q[i], spec_bytes[i]);
                end
                n_checks++;
                if (rx_t[i] != p + 1 + 10 * CPB * i) begin
                    n_fail++; $display("FAIL single_start%0d: got cycle %0d required %0d", i, rx_t[i], p + 1 + 10 * CPB * i);
                end
            end
        end
        n_checks++; if (rx_ferr != 0) begin n_fail++; $display("FAIL single_framing: got %0d errors required 0", rx_ferr); end
        n_checks++; if (busy_cnt != W) begin n_fail++; $display("FAIL single_busy_len: got %0d cycles required %0d", busy_cnt, W); end
    endtask

    task automatic test_back_to_back();
        clear_streams();
        push_word(16'h0000);
        push_word(16'hFFFF);
        add_exp(16'h0000);
        add_exp(16'hFFFF);
        wait_drain();
        n_checks++;
        if (stream_diff() != -1) begin
            n_fail++; $display("FAIL extremes_stream: %0d bytes, first diff at %0d, required %0d bytes", rx_q.size(), stream_diff(), exp_q.size());
        end
        n_checks++;
        if (rx_t.size() < 6) begin
            n_fail++; $display("FAIL extremes_gap: got %0d bytes required 10", rx_t.size());
        end else if (rx_t[5] - rx_t[0] != W + 1) begin
            n_fail++; $display("FAIL extremes_gap: got spacing %0d required %0d", rx_t[5] - rx_t[0], W + 1);
        end
    endtask

    task automatic test_random_words();
        logic [15:0] w;
        clear_streams();
        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom);
            push_word(w);
            add_exp(w);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain();
        n_checks++;
        if (stream_diff() != -1) begin
            n_fail++; $display("FAIL random_stream: %0d bytes, first diff at %0d, required %0d bytes", rx_q.size(), stream_diff(), exp_q.size());
        end
        n_checks++; if (rx_ferr != 0) begin n_fail++; $display("FAIL random_framing: got %0d errors required 0", rx_ferr); end
    endtask

    task automatic test_overflow();
        clear_streams();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_initial: got %b required 0", overflow); end
        for (int i = 1; i <= 10; i++) begin
            push_word(16'(i));
            if (i <= 9) add_exp(16'(i));
            if (i == 9) begin
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %b required 0", overflow); end
            end
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b required 1", overflow); end
        wait_drain();
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
        n_checks++;
        if (stream_diff() != -1) begin
            n_fail++; $display("FAIL ovf_stream: %0d bytes, first diff at %0d, required %0d bytes", rx_q.size(), stream_diff(), exp_q.size());
        end
        apply_reset();
    endtask

    task automatic test_full_pop_edge();
        logic [15:0] w;
        int p;
        clear_streams();
        for (int i = 0; i < 9; i++) begin
            w = 16'($urandom);
            push_word(w);
            add_exp(w);
            if (i == 0) p = last_push;
        end
        while (cyc < p + W + 1) @(negedge clk);
        w = 16'($urandom);
        push_word(w);
        add_exp(w);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL popedge_no_ovf: got %b required 0", overflow); end
        push_word(16'($urandom));
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL popedge_still_full: got %b required 1", overflow); end
        wait_drain();
        n_checks++;
        if (stream_diff() != -1) begin
            n_fail++; $display("FAIL popedge_stream: %0d bytes, first diff at %0d, required %0d bytes", rx_q.size(), stream_diff(), exp_q.size());
        end
        apply_reset();
    endtask

    task automatic test_end_done();
        logic [15:0] w;
        int p, q;
        clear_streams();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_initial: got %b required 0", done); end
        w = 16'($urandom); push_word(w); add_exp(w);
        p = last_push;
        w = 16'($urandom); push_word(w); add_exp(w);
        done_rise = -1;
        busy_fall = -1;
        end_sig = 1'b1;
        @(negedge clk);
        end_sig = 1'b0;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_while_busy: got %b required 0", done); end
        wait_drain();
        n_checks++; if (done_rise != p + 2 + 2 * W) begin n_fail++; $display("FAIL done_rise: got cycle %0d required %0d", done_rise, p + 2 + 2 * W); end
        n_checks++; if (busy_fall != p + 2 + 2 * W) begin n_fail++; $display("FAIL busy_fall: got cycle %0d required %0d", busy_fall, p + 2 + 2 * W); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_after: got %b required 1", done); end
        w = 16'($urandom); push_word(w); add_exp(w);
        q = last_push;
        done_rise = -1;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_drop: got %b required 0", done); end
        wait_drain();
        n_checks++; if (done_rise != q + 1 + W) begin n_fail++; $display("FAIL done_rerise: got cycle %0d required %0d", done_rise, q + 1 + W); end
        n_checks++;
        if (stream_diff() != -1) begin
            n_fail++; $display("FAIL done_stream: %0d bytes, first diff at %0d, required %0d bytes", rx_q.size(), stream_diff(), exp_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] w;
        int p;
        clear_streams();
        end_sig = 1'b1;
        @(negedge clk);
        end_sig = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push_word(16'($urandom));
            if (i == 0) p = last_push;
        end
        while (cyc < p + 60) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (tx !== 1'b1)       begin n_fail++; $display("FAIL midrst_tx: got %b required 1", tx); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL midrst_busy: got %b required 0", busy); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_overflow: got %b required 0", overflow); end
        n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL midrst_done: got %b required 0", done); end
        clear_streams();
        rst = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_empty: busy got %b required 0", busy); end
        n_checks++; if (rx_q.size() != 0 || rx_act) begin n_fail++; $display("FAIL midrst_quiet: got %0d bytes required 0", rx_q.size()); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_endflag: done got %b required 0", done); end
        w = 16'($urandom);
        push_word(w);
        add_exp(w);
        wait_drain();
        n_checks++;
        if (stream_diff() != -1) begin
            n_fail++; $display("FAIL midrst_stream: %0d bytes, first diff at %0d, required %0d bytes", rx_q.size(), stream_diff(), exp_q.size());
        end
        n_checks++; if (rx_ferr != 0) begin n_fail++; $display("FAIL midrst_framing: got %0d errors required 0", rx_ferr); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_random_words();
        test_overflow();
        test_full_pop_edge();
        test_end_done();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vecaris_print_tx.md
# vecaris_print_tx

Serial print transmitter for the VECARIS core. It captures each word the core prints, buffers it in a small FIFO, and sends it on a UART line (8N1) as four uppercase ASCII hex digits followed by a line feed. It also reports when the program has ended and every captured word has been fully shifted out. It sits directly downstream of the core's print path and end signal, on the same clock.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; legal range 2..65535.
- `FIFO_DEPTH`, 8: number of words buffered; power of two, 2..64.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `print_en`  in  1: one-cycle strobe marking that `print_data` is a word the core prints.
- `print_data`  in  16: the printed word, valid in the cycle `print_en` is high.
- `end_sig`  in  1: core halt indication; level or pulse accepted.
- `tx`  out  1: UART serial output; idles high.
- `busy`  out  1: high while the FIFO is non-empty or a character frame is in progress.
- `overflow`  out  1: sticky flag; set when a strobe arrives with the FIFO full.
- `done`  out  1: high when `end_sig` has been seen, the FIFO is empty, and the FSM is IDLE.

## Operation
- **Reset** (`rst`=0 at a clock edge):
  - `tx`=1, `busy`=0, `overflow`=0, `done`=0.
  - FIFO is emptied and the FSM enters IDLE.
  - The end-seen flag is cleared.
  - Any frame in progress is abandoned; `tx` is high on the first cycle after the reset edge.
- **Push**:
  - If `print_en`=1 and the FIFO is not full, `print_data` is written at the edge.
  - If `print_en`=1 and the FIFO is full, the word is dropped and `overflow` is set. It clears only on reset.
- **Pop**:
  - In IDLE with the FIFO non-empty, the head word is popped into a 16-bit word register at the edge.
  - The character index is set to 0 and the FSM enters START.
- **Simultaneous push and pop on a full FIFO**: both happen; the word is accepted, the count is unchanged, and `overflow` is not set.
- **Empty FIFO**: there is no bypass path; a word always passes through the FIFO.
- **Characters**: index 0..3 selects nibble [15:12], [11:8], [7:4], [3:0]. Index 4 is 0x0A.
- **Nibble to ASCII**: 0–9 map to 0x30–0x39; A–F map to 0x41–0x46.
- **FSM states**:
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx` = current bit of the character, LSB first, 8 bits.
  - STOP: `tx`=1.
  - Each bit lasts exactly `CLKS_PER_BIT` cycles, counted by a bit timer.
- **Transitions**:
  - START → DATA.
  - DATA → STOP after bit 7.
  - STOP with index < 4 → START, with the index incremented. There is no idle gap between characters of one word.
  - STOP with index = 4 → IDLE.
- **End handling**: the end-seen flag is set on any edge where `end_sig`=1. Pushes after end are still accepted, and `done` drops until they drain.
- **Output registers**: `tx`, `busy`, and `done` are registered outputs.

## Timing
- Push at edge N on an empty FIFO while IDLE: pop at edge N+1; `tx` falls after edge N+1. That falling edge begins the start bit.
- Character frame = 10 × `CLKS_PER_BIT` cycles. Word = 50 × `CLKS_PER_BIT` cycles.
- After the last stop bit: one IDLE cycle, then the next pop if the FIFO is non-empty. Word-to-word spacing is 50 × `CLKS_PER_BIT` + 1 cycles.
- `busy` rises the cycle after the first push and falls the cycle after the last STOP completes with the FIFO empty.
- `done` rises in the same cycle `busy` falls, or the cycle after `end_sig` if the block is already idle and empty.
- Reset asserted mid-frame: all outputs hold their reset values from the next cycle. After release, no partial character is resumed.

## Test plan
- **Single word**: `CLKS_PER_BIT`=4, push 0x1A2F.
  - Bytes on `tx`: 0x31, 0x41, 0x32, 0x46, 0x0A.
  - Each byte lasts 40 cycles; the start bit begins 1 cycle after the push edge.
  - `busy` is high for exactly 200 cycles.
- **Digit extremes**: push 0x0000 then 0xFFFF back-to-back.
  - Output is "0000\n" then "FFFF\n".
  - Exactly one idle-high cycle separates the two words.
- **Overflow**: `FIFO_DEPTH`=8, 10 consecutive strobes, data 0x0001..0x000A.
  - Words 1–9 are transmitted; word 10 is dropped.
  - `overflow` sets at the 10th push edge and stays set.
- **Push on pop edge with a full FIFO**: the strobe is accepted, the count stays 8, and `overflow` stays 0.
- **End/done**: pulse `end_sig` with 2 words queued.
  - `done`=0 until the second line feed's stop bit ends, then 1.
  - A later push drops `done` until that word drains.
- **Reset mid-frame**: assert `rst`=0 during DATA of the second character.
  - Next cycle: `tx`=1, `busy`=0, `overflow`=0, `done`=0, FIFO empty.
  - A new push after release transmits cleanly.
